// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: 2-flop synchroniser, shared tick divider and a
// per-channel qualify FSM producing a clean level plus press/release/hold pulses.
module debounce_multi #(
    parameter int                  CHANNELS     = 4,
    parameter int                  CLK_DIV      = 500000,
    parameter int                  STABLE_TICKS = 4,
    parameter int                  HOLD_TICKS   = 200,
    parameter logic [CHANNELS-1:0] POLARITY     = {CHANNELS{1'b0}}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] key_i,
    output logic                tick_o,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] hold_o
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int QW = $clog2(STABLE_TICKS + 1);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_QUAL,
        PRESSED,
        RELEASE_QUAL
    } state_e;

    logic [DW-1:0]       div_q;
    logic                tick_q;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    // tick_q is decoded one count early so it is a flop that is high while div_q == CLK_DIV-1.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= POLARITY;
            sync2_q <= POLARITY;
        end else begin
            div_q   <= (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
            tick_q  <= (div_q == DW'(CLK_DIV - 2));
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign tick_o = tick_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_e        state_q, state_d;
        logic [QW-1:0] qcnt_q, qcnt_d;
        logic [HW-1:0] hcnt_q, hcnt_d;
        logic          s;
        logic          level_q, level_d;
        logic          press_q, release_q;
        logic          hold_q, hold_d;

        assign s = sync2_q[i] ^ POLARITY[i];

        // NOTE: every signal gets a default first so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            qcnt_d  = qcnt_q;
            if (tick_q) begin
                unique case (state_q)
                    RELEASED: if (s) begin
                        qcnt_d  = QW'(1);
                        state_d = (STABLE_TICKS == 1) ? PRESSED : PRESS_QUAL;
                    end
                    PRESS_QUAL: begin
                        if (!s) begin
                            state_d = RELEASED;
                            qcnt_d  = '0;
                        end else if (qcnt_q == QW'(STABLE_TICKS - 1)) begin
                            state_d = PRESSED;
                            qcnt_d  = '0;
                        end else begin
                            qcnt_d = qcnt_q + QW'(1);
                        end
                    end
                    PRESSED: if (!s) begin
                        qcnt_d  = QW'(1);
                        state_d = (STABLE_TICKS == 1) ? RELEASED : RELEASE_QUAL;
                    end
                    RELEASE_QUAL: begin
                        if (s) begin
                            state_d = PRESSED;
                            qcnt_d  = '0;
                        end else if (qcnt_q == QW'(STABLE_TICKS - 1)) begin
                            state_d = RELEASED;
                            qcnt_d  = '0;
                        end else begin
                            qcnt_d = qcnt_q + QW'(1);
                        end
                    end
                    default: state_d = RELEASED;
                endcase
            end

            level_d = (state_d == PRESSED) || (state_d == RELEASE_QUAL);

            // Hold count restarts on a fresh press and is zeroed whenever the channel is released.
            hcnt_d = hcnt_q;
            hold_d = 1'b0;
            if (tick_q) begin
                if (state_d == RELEASED ||
                    (state_d == PRESSED && (state_q == RELEASED || state_q == PRESS_QUAL))) begin
                    hcnt_d = '0;
                end else if (level_q && hcnt_q != HW'(HOLD_TICKS)) begin
                    hcnt_d = hcnt_q + HW'(1);
                    hold_d = (hcnt_q == HW'(HOLD_TICKS - 1));
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q   <= RELEASED;
                qcnt_q    <= '0;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                hold_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                qcnt_q    <= qcnt_d;
                hcnt_q    <= hcnt_d;
                level_q   <= level_d;
                press_q   <= level_d & ~level_q;
                release_q <= ~level_d & level_q;
                hold_q    <= hold_d;
            end
        end

        assign level_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = release_q;
        assign hold_o[i]    = hold_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (polarity 00 and 10) driven by directed
// and random key patterns, compared every cycle against a run-length reference model.
module tb_debounce_multi;

    localparam int DIV = 4;
    localparam int ST  = 3;
    localparam int HT  = 5;
    localparam logic [3:0] POL = 4'b1000;  // {b1, b0, a1, a0}

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_a, key_b;
    logic       tick_a, tick_b;
    logic [1:0] level_a, press_a, release_a, hold_a;
    logic [1:0] level_b, press_b, release_b, hold_b;

    always #5 clk = ~clk;

    debounce_multi #(.CHANNELS(2), .CLK_DIV(DIV), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                     .POLARITY(2'b00)) dut_a (
        .clk_i(clk), .rst_i(rst), .key_i(key_a), .tick_o(tick_a), .level_o(level_a),
        .press_o(press_a), .release_o(release_a), .hold_o(hold_a));

    debounce_multi #(.CHANNELS(2), .CLK_DIV(DIV), .STABLE_TICKS(ST), .HOLD_TICKS(HT),
                     .POLARITY(2'b10)) dut_b (
        .clk_i(clk), .rst_i(rst), .key_i(key_b), .tick_o(tick_b), .level_o(level_b),
        .press_o(press_b), .release_o(release_b), .hold_o(hold_b));

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: level flips after ST consecutive disagreeing tick samples.
    int         m_cyc;
    logic       m_tick;
    logic [3:0] m_lvl, m_h1, m_h2, e_press, e_rel, e_hold;
    int         m_run  [4];
    int         m_held [4];

    // Window counters of observed DUT behaviour.
    int n_tick, n_pa0, n_pa1, n_ra0, n_ha0, n_pb11, n_rb, n_pb;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc   = 0;
        m_tick  = 1'b0;
        m_lvl   = '0;
        m_h1    = POL;
        m_h2    = POL;
        e_press = '0;
        e_rel   = '0;
        e_hold  = '0;
        for (int c = 0; c < 4; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
    endtask

    task automatic model_edge();
        logic       tb_en;
        logic [3:0] keys;
        logic       s, was;
        tb_en = m_tick;
        keys  = {key_b, key_a};
        if (rst) begin
            model_reset();
        end else begin
            m_cyc++;
            m_tick = (m_cyc % DIV == DIV - 1);
            for (int c = 0; c < 4; c++) begin
                s        = m_h2[c] ^ POL[c];
                m_h2[c]  = m_h1[c];
                m_h1[c]  = keys[c];
                e_press[c] = 1'b0;
                e_rel[c]   = 1'b0;
                e_hold[c]  = 1'b0;
                if (tb_en) begin
                    was = m_lvl[c];
                    if (s != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == ST) begin
                            m_lvl[c] = s;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (m_lvl[c] && !was) begin
                        e_press[c] = 1'b1;
                        m_held[c]  = 0;
                    end else if (!m_lvl[c] && was) begin
                        e_rel[c]  = 1'b1;
                        m_held[c] = 0;
                    end else if (m_lvl[c] && m_held[c] < HT) begin
                        m_held[c]++;
                        if (m_held[c] == HT) e_hold[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tick",    {2'b00, tick_b, tick_a}, {2'b00, m_tick, m_tick});
        chk("level",   {level_b, level_a},      m_lvl);
        chk("press",   {press_b, press_a},      e_press);
        chk("release", {release_b, release_a},  e_rel);
        chk("hold",    {hold_b, hold_a},        e_hold);
        n_tick += int'(tick_a);
        n_pa0  += int'(press_a[0]);
        n_pa1  += int'(press_a[1]);
        n_ra0  += int'(release_a[0]);
        n_ha0  += int'(hold_a[0]);
        n_pb11 += int'(press_b == 2'b11);
        n_pb   += int'(press_b != 2'b00);
        n_rb   += int'(release_b != 2'b00);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        n_tick = 0; n_pa0 = 0; n_pa1 = 0; n_ra0 = 0;
        n_ha0  = 0; n_pb11 = 0; n_rb = 0; n_pb = 0;
    endtask

    initial begin
        rst   = 1'b1;
        key_a = 2'b00;
        key_b = 2'b10;
        model_reset();
        clear_counts();

        // Reset with keys idle, then three ticks in the first 12 cycles.
        run(3);
        chk("rst_outputs", {level_a, press_a | release_a | hold_a}, 4'b0000);
        rst = 1'b0;
        clear_counts();
        run(12);
        chk("tick_count_12", 4'(n_tick), 4'd3);
        chk("idle_no_press", 4'(n_pa0 + n_pa1 + n_pb), 4'd0);

        // Steady press on ch0 of dut_a.
        key_a = 2'b01;
        clear_counts();
        run(20);
        chk("press_once",  4'(n_pa0), 4'd1);
        chk("press_ch1_0", 4'(n_pa1), 4'd0);
        chk("level_after_press", {2'b00, level_a}, 4'b0001);

        // Hold pulse, exactly one, then none for twenty more ticks.
        run(30);
        chk("hold_once", 4'(n_ha0), 4'd1);
        clear_counts();
        run(80);
        chk("hold_no_repeat", 4'(n_ha0), 4'd0);
        chk("level_held", {2'b00, level_a}, 4'b0001);

        // One-tick release glitch, then a clean release.
        key_a = 2'b00;
        clear_counts();
        run(4);
        key_a = 2'b01;
        run(12);
        chk("glitch_no_release", 4'(n_ra0), 4'd0);
        chk("glitch_level", {2'b00, level_a}, 4'b0001);
        key_a = 2'b00;
        run(20);
        chk("release_once", 4'(n_ra0), 4'd1);
        chk("level_released", {2'b00, level_a}, 4'b0000);

        // Two-tick press aborts; three-tick press qualifies.
        clear_counts();
        key_a = 2'b01;
        run(8);
        key_a = 2'b00;
        run(12);
        chk("short_no_press", 4'(n_pa0), 4'd0);
        key_a = 2'b01;
        run(12);
        key_a = 2'b00;
        run(8);
        chk("three_tick_press", 4'(n_pa0), 4'd1);
        run(20);

        // Mixed polarity instance: simultaneous press, then reset while pressed.
        clear_counts();
        key_b = 2'b01;
        run(20);
        chk("both_press_same_cycle", 4'(n_pb11), 4'd1);
        chk("level_b_pressed", {2'b00, level_b}, 4'b0011);
        clear_counts();
        rst = 1'b1;
        run(2);
        chk("rst_clears_level", {2'b00, level_b}, 4'b0000);
        rst = 1'b0;
        run(24);
        chk("rst_no_release", 4'(n_rb), 4'd0);
        chk("repress_after_rst", {2'b00, level_b}, 4'b0011);

        // Random segments of key activity, with an occasional reset.
        for (int seg = 0; seg < 80; seg++) begin
            key_a = 2'($urandom_range(0, 3));
            key_b = 2'($urandom_range(0, 3));
            rst   = ($urandom_range(0, 39) == 0);
            run(1);
            rst = 1'b0;
            run(int'($urandom_range(1, 24)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
